// File: rtl/seq_gen_if.sv
// Operator command and display-feed bundle for the sequence generator.
// The master drives commands; the slave returns registered display data.
interface seq_gen_if;
  logic        start;
  logic        stop;
  logic [2:0]  prog_sel;
  logic [1:0]  mod_sel;
  logic [2:0]  prog;
  logic [1:0]  modulo;
  logic [15:0] data_2;
  logic        running;

  modport master (
    output start, stop, prog_sel, mod_sel,
    input  prog, modulo, data_2, running
  );

  modport slave (
    input  start, stop, prog_sel, mod_sel,
    output prog, modulo, data_2, running
  );
endinterface

// File: rtl/seq_gen.sv
// Eight-program numeric sequence generator with run/pause control
// and a speed-scaled step prescaler; all outputs registered.
module seq_gen #(
  parameter int TICK_BASE = 100_000_000
) (
  input  logic      clk,
  input  logic      rst,
  seq_gen_if.slave  bus
);

  localparam int CW = (TICK_BASE > 1) ? $clog2(TICK_BASE) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   val_q, val_d;
  logic [15:0]   prev_q, prev_d;
  logic [7:0]    n_q, n_d;
  logic [2:0]    prog_q, prog_d;
  logic [1:0]    mod_q, mod_d;
  logic          run_q, run_d;

  logic [CW-1:0] last_cnt;
  logic [16:0]   cand;
  logic          wrap;
  logic [15:0]   step_val;
  logic [15:0]   step_prev;
  logic [7:0]    step_n;

  function automatic logic [15:0] first_val(input logic [2:0] p);
    logic [15:0] v;
    v = 16'd0;
    if (p == 3'd1) v = 16'd9999;
    else if (p == 3'd3 || p == 3'd5) v = 16'd1;
    return v;
  endfunction

  assign last_cnt = CW'((TICK_BASE >> mod_q) - 1);

  // Candidate next value is 17 bits wide so the wrap test cannot overflow.
  always_comb begin
    cand = {1'b0, val_q} + 17'd1;
    unique case (prog_q)
      3'd0: cand = {1'b0, val_q} + 17'd1;
      3'd1: cand = {1'b0, val_q} - 17'd1;
      3'd2: cand = {1'b0, val_q} + {1'b0, prev_q};
      3'd3: cand = {val_q, 1'b0};
      3'd4,
      3'd5: cand = {1'b0, val_q} + 17'd2;
      3'd6: cand = {1'b0, val_q} + {8'd0, n_q, 1'b1};
      3'd7: cand = {1'b0, val_q} + {9'd0, n_q} + 17'd1;
      default: cand = {1'b0, val_q} + 17'd1;
    endcase
    wrap = (prog_q == 3'd1) ? (val_q == 16'd0) : (cand > 17'd9999);
    step_val  = wrap ? first_val(prog_q) : cand[15:0];
    step_prev = wrap ? 16'd1 : val_q;
    step_n    = wrap ? 8'd0 : n_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    val_d   = val_q;
    prev_d  = prev_q;
    n_d     = n_q;
    prog_d  = prog_q;
    mod_d   = mod_q;
    run_d   = run_q;
    unique case (state_q)
      IDLE: begin
        if (!bus.stop && bus.start) begin
          state_d = RUN;
          run_d   = 1'b1;
          prog_d  = bus.prog_sel;
          mod_d   = bus.mod_sel;
          val_d   = first_val(bus.prog_sel);
          prev_d  = 16'd1;
          n_d     = 8'd0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = PAUSE;
          run_d   = 1'b0;
        end else if (cnt_q == last_cnt) begin
          cnt_d  = '0;
          val_d  = step_val;
          prev_d = step_prev;
          n_d    = step_n;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      PAUSE: begin
        if (bus.stop) begin
          state_d = IDLE;
          val_d   = 16'd0;
        end else if (bus.start) begin
          state_d = RUN;
          run_d   = 1'b1;
          mod_d   = bus.mod_sel;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        run_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      val_q   <= 16'd0;
      prev_q  <= 16'd0;
      n_q     <= 8'd0;
      prog_q  <= 3'd0;
      mod_q   <= 2'd0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      val_q   <= val_d;
      prev_q  <= prev_d;
      n_q     <= n_d;
      prog_q  <= prog_d;
      mod_q   <= mod_d;
      run_q   <= run_d;
    end
  end

  assign bus.prog    = prog_q;
  assign bus.modulo  = mod_q;
  assign bus.data_2  = val_q;
  assign bus.running = run_q;

endmodule

// File: tb/tb_seq_gen.sv
// Directed bench for seq_gen with a short prescaler base.
// Inputs change and outputs are sampled on the falling edge.
module tb_seq_gen;

  localparam int TB = 8;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   mx;
  int   fib [23] = '{0, 1, 1, 2, 3, 5, 8, 13, 21, 34, 55, 89, 144,
                     233, 377, 610, 987, 1597, 2584, 4181, 6765, 0, 1};

  seq_gen_if bus ();

  seq_gen #(.TICK_BASE(TB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic go(input logic [2:0] p, input logic [1:0] m);
    bus.prog_sel = p;
    bus.mod_sel  = m;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
  endtask

  task automatic resume(input logic [1:0] m);
    bus.mod_sel = m;
    bus.start   = 1'b1;
    @(negedge clk);
    bus.start   = 1'b0;
  endtask

  task automatic stp();
    bus.stop = 1'b1;
    @(negedge clk);
    bus.stop = 1'b0;
  endtask

  task automatic tick_max(input int n);
    repeat (n) begin
      @(negedge clk);
      if (int'(bus.data_2) > mx) mx = int'(bus.data_2);
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.prog_sel = 3'd0;
    bus.mod_sel  = 2'd0;
    #1 rst = 1'b0;
    #1;
    chk("rst_data", 32'(bus.data_2), 0);
    chk("rst_prog", 32'(bus.prog), 0);
    chk("rst_mod", 32'(bus.modulo), 0);
    chk("rst_run", 32'(bus.running), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    go(3'd0, 2'd0);
    chk("up_run", 32'(bus.running), 1);
    chk("up_prog", 32'(bus.prog), 0);
    chk("up_first", 32'(bus.data_2), 0);
    tick(8);
    chk("up_p1", 32'(bus.data_2), 1);
    tick(8);
    chk("up_p2", 32'(bus.data_2), 2);
    tick(24);
    chk("up_p5", 32'(bus.data_2), 5);
    stp();
    chk("pause_run", 32'(bus.running), 0);
    tick(100);
    chk("pause_hold", 32'(bus.data_2), 5);
    chk("pause_run2", 32'(bus.running), 0);
    resume(2'd2);
    chk("res_mod", 32'(bus.modulo), 2);
    chk("res_run", 32'(bus.running), 1);
    tick(1);
    chk("res_c1", 32'(bus.data_2), 5);
    tick(1);
    chk("res_c2", 32'(bus.data_2), 6);
    stp();
    stp();
    chk("idle_data", 32'(bus.data_2), 0);
    chk("idle_run", 32'(bus.running), 0);
    chk("idle_prog", 32'(bus.prog), 0);
    chk("idle_mod", 32'(bus.modulo), 2);

    bus.prog_sel = 3'd5;
    bus.start    = 1'b1;
    bus.stop     = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    chk("both_run", 32'(bus.running), 0);
    chk("both_prog", 32'(bus.prog), 0);
    tick(3);
    chk("both_run2", 32'(bus.running), 0);

    go(3'd0, 2'd1);
    tick(3);
    stp();
    chk("coin_run", 32'(bus.running), 0);
    chk("coin_data", 32'(bus.data_2), 0);
    resume(2'd1);
    tick(4);
    chk("coin_res", 32'(bus.data_2), 1);
    stp();
    stp();

    go(3'd2, 2'd3);
    for (int i = 0; i < 23; i++) begin
      chk($sformatf("fib%0d", i), 32'(bus.data_2), 32'(fib[i]));
      tick(1);
    end
    stp();
    stp();

    go(3'd6, 2'd3);
    mx = 0;
    tick_max(99);
    chk("sq_last", 32'(bus.data_2), 9801);
    tick_max(1);
    chk("sq_wrap", 32'(bus.data_2), 0);
    tick_max(1);
    chk("sq_after", 32'(bus.data_2), 1);
    chk("sq_max", 32'(mx <= 9999), 1);
    stp();
    stp();

    go(3'd7, 2'd3);
    mx = 0;
    tick_max(140);
    chk("tri_last", 32'(bus.data_2), 9870);
    tick_max(1);
    chk("tri_wrap", 32'(bus.data_2), 0);
    chk("tri_max", 32'(mx <= 9999), 1);
    stp();
    stp();

    go(3'd3, 2'd3);
    chk("pw_first", 32'(bus.data_2), 1);
    tick(13);
    chk("pw_last", 32'(bus.data_2), 8192);
    tick(1);
    chk("pw_wrap", 32'(bus.data_2), 1);
    stp();
    stp();

    go(3'd1, 2'd3);
    chk("dn_first", 32'(bus.data_2), 9999);
    tick(1);
    chk("dn_1", 32'(bus.data_2), 9998);
    tick(9998);
    chk("dn_zero", 32'(bus.data_2), 0);
    tick(1);
    chk("dn_wrap", 32'(bus.data_2), 9999);
    stp();
    stp();

    go(3'd4, 2'd3);
    chk("ev_first", 32'(bus.data_2), 0);
    tick(4999);
    chk("ev_last", 32'(bus.data_2), 9998);
    tick(1);
    chk("ev_wrap", 32'(bus.data_2), 0);
    stp();
    stp();

    go(3'd5, 2'd3);
    chk("od_first", 32'(bus.data_2), 1);
    tick(4999);
    chk("od_last", 32'(bus.data_2), 9999);
    tick(1);
    chk("od_wrap", 32'(bus.data_2), 1);
    stp();
    stp();

    go(3'd0, 2'd3);
    tick(9999);
    chk("up_last", 32'(bus.data_2), 9999);
    tick(1);
    chk("up_wrap", 32'(bus.data_2), 0);
    tick(3);
    chk("up_3", 32'(bus.data_2), 3);

    #2 rst = 1'b0;
    #1;
    chk("arst_data", 32'(bus.data_2), 0);
    chk("arst_prog", 32'(bus.prog), 0);
    chk("arst_mod", 32'(bus.modulo), 0);
    chk("arst_run", 32'(bus.running), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_run", 32'(bus.running), 0);
    chk("post_data", 32'(bus.data_2), 0);
    tick(5);
    chk("post_idle", 32'(bus.data_2), 0);
    chk("post_run2", 32'(bus.running), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_gen.md
# seq_gen

Numeric sequence generator that feeds the 8-digit display manager. On operator command it runs one of eight integer sequences, advancing at a rate chosen by a 2-bit speed code, and presents the current value (always 0..9999), the running program number and the speed code on registered outputs. The display manager consumes these as its `data_2`, `prog` and `modulo` inputs.

## Interface
- `TICK_BASE`, default 100_000_000: clock cycles per step at speed 0 (1 Hz at 100 MHz); must be a multiple of 8, minimum 8.
- `clk` in 1: system clock, all state on rising edge.
- `rst` in 1: asynchronous, active-low reset (asserted at 0).
- `start` in 1: one-cycle pulse (already debounced): run from IDLE, resume from PAUSE.
- `stop` in 1: one-cycle pulse: RUN→PAUSE, PAUSE→IDLE.
- `prog_sel` in 3: requested program, sampled only on start from IDLE.
- `mod_sel` in 2: requested speed, sampled on every accepted start.
- `prog` out 3: latched program number.
- `modulo` out 2: latched speed code.
- `data_2` out 16: current sequence value, binary, 0..9999.
- `running` out 1: high in RUN only.

## Operation
- States: IDLE, RUN, PAUSE. On reset: IDLE, `prog`=0, `modulo`=0, `data_2`=0, `running`=0, prescaler=0, all sequence registers 0.
- IDLE + start: latch `prog_sel`→`prog` and `mod_sel`→`modulo`, load the program's first value into `data_2`, clear prescaler, go RUN.
- RUN + stop: go PAUSE; `data_2` and sequence state held.
- PAUSE + start: latch `mod_sel`→`modulo` (`prog` unchanged), clear prescaler, go RUN.
- PAUSE + stop: go IDLE, `data_2`=0; `prog` and `modulo` keep their last values.
- start and stop in the same cycle: stop wins, start ignored. start in RUN and stop in IDLE are ignored.
- Step period P = TICK_BASE >> `modulo` (speed 0..3 = 1, 2, 4, 8 steps/s at default).
- Program sequences: first value, then step rule, then wrap condition and wrap value.
  - 0 up count: starts at 0; steps +1; after 9999 wraps to 0.
  - 1 down count: starts at 9999; steps −1; after 0 wraps to 9999.
  - 2 Fibonacci: 0, 1, 1, 2, 3, …, 6765; if the next term would exceed 9999, restart at 0, 1.
  - 3 powers of two: 1, 2, 4, …, 8192; after 8192 wraps to 1.
  - 4 even: 0, 2, …, 9998; after 9998 wraps to 0.
  - 5 odd: 1, 3, …, 9999; after 9999 wraps to 1.
  - 6 squares: 0, 1, 4, …, 9801 (n = 0..99), computed incrementally as value + 2n + 1; after 9801 wraps to 0.
  - 7 triangular: 0, 1, 3, 6, …, 9870 (n = 0..140), computed as value + n + 1; after 9870 wraps to 0.
- Arithmetic:
  - No multipliers.
  - The wrap test uses the candidate next value, computed in 17 bits, so there is no overflow.
  - `data_2` never exceeds 9999.
  - Index n is 8 bits and resets to 0 on every wrap and on every start from IDLE.

## Timing
- Every output is a register; no combinational input-to-output path.
- Start accepted in cycle k: `running`, `prog`, `modulo` and the first value are visible after edge k+1.
- Prescaler counts 0..P−1 in RUN only; it is frozen in PAUSE and IDLE.
  - The step fires on the edge where the count equals P−1, and the count returns to 0.
  - First step after entering RUN: P cycles after the entry edge, then every P cycles.
- stop in the same cycle as a step: the stop takes effect and the step is suppressed; `data_2` is unchanged.
- Resume from PAUSE restarts a full period P (no partial-period carry-over).
- Reset asserted mid-run: all outputs reach their reset values immediately (asynchronous), independent of `clk`. Release is synchronous to the next edge.

## Test plan
- TICK_BASE=8, prog_sel=0, mod_sel=0, start -> `data_2` = 0, then 1 after 8 cycles, 2 after 16; preload to 9999 via long run -> next step gives 0.
- prog_sel=2, mod_sel=3 (P=1), start -> `data_2` each cycle 0,1,1,2,3,5,…,6765,0,1 (21-term period).
- prog_sel=6 and 7, mod_sel=3 -> squares end at 9801 then 0; triangular end at 9870 then 0; no value > 9999.
- RUN prog 0 at value 5, stop -> `running`=0 and value held 5 for 100 cycles; start with mod_sel=2 -> `modulo`=2, value 6 exactly 2 cycles later; stop, stop -> IDLE, `data_2`=0.
- start and stop in the same cycle in IDLE -> remains IDLE; in RUN, stop coincident with a step -> PAUSE and value not incremented.
- Assert `rst`=0 mid-run between clock edges -> `data_2`, `prog`, `modulo`, `running` read 0 before the next edge; after release, IDLE.
